// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller: state codes,
// coin denominations and packed-price lookup.
package vend_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE     = 2'd0;
    localparam state_t S_CREDIT   = 2'd1;
    localparam state_t S_DISPENSE = 2'd2;
    localparam state_t S_CHANGE   = 2'd3;

    localparam logic [2:0] COIN_1 = 3'd1;
    localparam logic [2:0] COIN_2 = 3'd2;
    localparam logic [2:0] COIN_5 = 3'd5;

    // Price bus is widened to the largest supported table (16 products x 16 bits).
    localparam int PRICE_MAX_W = 16;
    localparam int PRICE_BUS_W = 256;

    function automatic logic [PRICE_MAX_W-1:0] price_of(input logic [PRICE_BUS_W-1:0] prices,
                                                         input int idx,
                                                         input int width);
        logic [PRICE_BUS_W-1:0] shifted;
        logic [PRICE_BUS_W-1:0] mask;
        shifted = prices >> (idx * width);
        mask    = (PRICE_BUS_W'(1) << width) - PRICE_BUS_W'(1);
        return PRICE_MAX_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Change payout: holds the amount still owed, offers greedy 5/2/1 coins over
// a valid/ready handshake and flags the final accepted coin.
module vend_change_unit
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CREDIT_W-1:0] start_amount,
    input  logic                change_ready,
    output logic                change_valid,
    output logic [2:0]          change_value,
    output logic [CREDIT_W-1:0] rem,
    output logic                done
);

    function automatic logic [2:0] pick_coin(input logic [CREDIT_W-1:0] amt);
        if (amt >= CREDIT_W'(5))      return COIN_5;
        else if (amt >= CREDIT_W'(2)) return COIN_2;
        else                          return COIN_1;
    endfunction

    logic                handshake;
    logic [CREDIT_W-1:0] rem_next;

    assign handshake = change_valid & change_ready;
    assign rem_next  = rem - CREDIT_W'(change_value);
    assign done      = handshake && (rem_next == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem          <= '0;
            change_valid <= 1'b0;
            change_value <= 3'd0;
        end else if (start) begin
            rem          <= start_amount;
            change_valid <= (start_amount != '0);
            change_value <= pick_coin(start_amount);
        end else if (handshake) begin
            rem <= rem_next;
            if (rem_next == '0) begin
                change_valid <= 1'b0;
                change_value <= 3'd0;
            end else begin
                change_value <= pick_coin(rem_next);
            end
        end
    end

endmodule

// File: rtl/vend_multi_controller.sv
// Multi-product coin vending controller: credit accumulation, selection with
// price/stock checks, one-cycle dispense, cancel/refund and change payout.
//
//   state      | meaning
//   S_IDLE     | no credit held, accepting coins
//   S_CREDIT   | credit > 0, accepting coins, select or cancel
//   S_DISPENSE | single cycle, dispense pulse for the latched product
//   S_CHANGE   | change unit paying out the remaining amount
module vend_multi_controller
    import vend_pkg::*;
#(
    parameter int                            NUM_PROD   = 4,
    parameter int                            CREDIT_W   = 8,
    parameter logic [NUM_PROD*CREDIT_W-1:0]  PRICES     = {8'd10, 8'd7, 8'd5, 8'd3},
    parameter int                            MAX_CREDIT = 50,
    parameter int                            STOCK_W    = 4,
    parameter int                            STOCK_INIT = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          coin_valid,
    input  logic [2:0]                    coin_value,
    output logic                          coin_reject,
    input  logic                          sel_valid,
    input  logic [$clog2(NUM_PROD)-1:0]   sel_id,
    output logic                          sel_error,
    input  logic                          cancel,
    input  logic                          restock,
    output logic                          dispense_valid,
    output logic [$clog2(NUM_PROD)-1:0]   dispense_id,
    output logic                          change_valid,
    output logic [2:0]                    change_value,
    input  logic                          change_ready,
    output logic [CREDIT_W-1:0]           credit,
    output logic                          busy
);

    localparam int ID_W = $clog2(NUM_PROD);

    state_t              state;
    logic [CREDIT_W-1:0] credit_r;
    logic [STOCK_W-1:0]  stock [NUM_PROD];

    logic                sel_known;
    logic [CREDIT_W-1:0] sel_price;
    logic [STOCK_W-1:0]  sel_stock;
    logic                in_front, sel_ok, do_cancel, do_sel, sel_bad;
    logic                coin_legal, coin_fits, coin_take;
    logic [CREDIT_W:0]   coin_sum;
    logic                cu_start, cu_done;
    logic [CREDIT_W-1:0] cu_rem;

    // Lookup by loop so an out-of-range sel_id simply matches nothing.
    always_comb begin
        sel_known = 1'b0;
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel_id == ID_W'(i)) begin
                sel_known = 1'b1;
                sel_price = CREDIT_W'(price_of(PRICE_BUS_W'(PRICES), i, CREDIT_W));
                sel_stock = stock[i];
            end
        end
    end

    assign in_front   = (state == S_IDLE) || (state == S_CREDIT);
    assign sel_ok     = sel_known && (sel_stock != '0) && (credit_r >= sel_price);
    assign do_cancel  = (state == S_CREDIT) && cancel;
    assign do_sel     = in_front && !do_cancel && sel_valid && sel_ok;
    assign sel_bad    = in_front && !do_cancel && sel_valid && !sel_ok;
    assign coin_legal = (coin_value == COIN_1) || (coin_value == COIN_2) || (coin_value == COIN_5);
    assign coin_sum   = {1'b0, credit_r} + (CREDIT_W+1)'(coin_value);
    assign coin_fits  = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign coin_take  = in_front && !do_cancel && !do_sel && coin_valid && coin_legal && coin_fits;
    assign cu_start   = ((state == S_DISPENSE) && (credit_r != '0)) || do_cancel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            credit_r       <= '0;
            coin_reject    <= 1'b0;
            sel_error      <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_id    <= '0;
        end else begin
            coin_reject    <= coin_valid && !coin_take;
            sel_error      <= sel_bad;
            dispense_valid <= do_sel;
            case (state)
                S_IDLE, S_CREDIT: begin
                    if (do_cancel) begin
                        state <= S_CHANGE;
                    end else if (do_sel) begin
                        dispense_id <= sel_id;
                        credit_r    <= credit_r - sel_price;
                        state       <= S_DISPENSE;
                    end else if (coin_take) begin
                        credit_r <= coin_sum[CREDIT_W-1:0];
                        state    <= S_CREDIT;
                    end
                end
                S_DISPENSE: state <= (credit_r != '0) ? S_CHANGE : S_IDLE;
                S_CHANGE: begin
                    if (cu_done) begin
                        state    <= S_IDLE;
                        credit_r <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Restock wins over a same-cycle purchase decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (restock) begin
            for (int i = 0; i < NUM_PROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int i = 0; i < NUM_PROD; i++) begin
                if (do_sel && (sel_id == ID_W'(i))) stock[i] <= stock[i] - 1'b1;
            end
        end
    end

    vend_change_unit #(.CREDIT_W(CREDIT_W)) u_change (
        .clk          (clk),
        .reset        (reset),
        .start        (cu_start),
        .start_amount (credit_r),
        .change_ready (change_ready),
        .change_valid (change_valid),
        .change_value (change_value),
        .rem          (cu_rem),
        .done         (cu_done)
    );

    assign credit = (state == S_CHANGE) ? cu_rem : credit_r;
    assign busy   = (state == S_DISPENSE) || (state == S_CHANGE);

endmodule
